// File: rtl/display_mode_ctrl.sv
// ---------------------------------------------------------------------------
// display_mode_ctrl
//
// Display-mode sequencer for the stopwatch/timer board. Owns the mode FSM that
// chooses what the output selector shows (blank, stopwatch, countdown timer or
// a stored lap value) and a small lap buffer whose currently selected entry is
// presented on mem. A countdown expiry forces a temporary ALARM view that is
// left again on any button press or after ALARM_CYC cycles, returning to the
// view that was active before the alarm.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   mode_btn       1-cycle pulse, advance display mode
//   lap_btn        1-cycle pulse, store stopwatch value (stopwatch view only)
//   recall_btn     1-cycle pulse, step to next lap entry (recall view only)
//   clear_btn      1-cycle pulse, erase lap buffer (recall view only)
//   timer_done     1-cycle pulse, countdown timer expired
//   stopwatch      current stopwatch value
//   output_select  selector code: 0 blank, 1 stopwatch, 2 timer, 3 memory
//   mem            lap entry at mem_idx
//   mem_idx        index of the displayed lap entry
//   lap_count      number of valid lap entries
//   alarm          high while the alarm view is active
// ---------------------------------------------------------------------------
module display_mode_ctrl #(
   parameter int W         = 12,
   parameter int DEPTH     = 4,
   parameter int ALARM_CYC = 1000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mode_btn,
   input  logic                         lap_btn,
   input  logic                         recall_btn,
   input  logic                         clear_btn,
   input  logic                         timer_done,
   input  logic [W-1:0]                 stopwatch,
   output logic [1:0]                   output_select,
   output logic [W-1:0]                 mem,
   output logic [$clog2(DEPTH)-1:0]     mem_idx,
   output logic [$clog2(DEPTH+1)-1:0]   lap_count,
   output logic                         alarm
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(ALARM_CYC + 1);

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_SW     = 3'd1,
      ST_TMR    = 3'd2,
      ST_RECALL = 3'd3,
      ST_ALARM  = 3'd4
   } state_t;

   state_t          state;
   state_t          state_n;
   state_t          saved;
   state_t          saved_n;
   logic [AW-1:0]   alarm_cnt;
   logic [AW-1:0]   alarm_cnt_n;
   logic [CW-1:0]   lap_count_n;
   logic [IW-1:0]   mem_idx_n;
   logic [W-1:0]    lap_buf [DEPTH];
   logic            buf_wr;
   logic            buf_clr;
   logic            any_btn;
   logic            alarm_done;
   logic            buf_full;
   logic            idx_last;

   // Helper conditions. idx_last is evaluated in the wider lap_count domain
   // so that "last valid entry" compares correctly even when the buffer is
   // completely full and lap_count no longer fits in the index width.
   always_comb begin
      any_btn    = mode_btn | lap_btn | recall_btn | clear_btn;
      alarm_done = (alarm_cnt == AW'(ALARM_CYC - 1));
      buf_full   = (lap_count == CW'(DEPTH));
      idx_last   = ((CW'(mem_idx) + CW'(1)) == lap_count);
   end

   // Next-state logic. Exactly one event is honoured per cycle, chosen by
   // the fixed priority timer_done > clear > mode > lap/recall; whatever
   // lower-priority pulses arrive alongside it are simply dropped, even when
   // the winning pulse has no effect in the current state. While the alarm
   // is showing, every button press only acknowledges it. A repeated
   // timer_done during the alarm restarts the hold time but keeps the view
   // saved on the first expiry, so the alarm always returns to a real mode.
   always_comb begin
      state_n     = state;
      saved_n     = saved;
      alarm_cnt_n = alarm_cnt;
      lap_count_n = lap_count;
      mem_idx_n   = mem_idx;
      buf_wr      = 1'b0;
      buf_clr     = 1'b0;

      if (timer_done) begin
         if (state != ST_ALARM) begin
            saved_n = state;
         end
         state_n     = ST_ALARM;
         alarm_cnt_n = '0;
      end else if (state == ST_ALARM) begin
         if (any_btn || alarm_done) begin
            state_n     = saved;
            alarm_cnt_n = '0;
         end else begin
            alarm_cnt_n = alarm_cnt + AW'(1);
         end
      end else if (clear_btn) begin
         if (state == ST_RECALL) begin
            state_n     = ST_OFF;
            lap_count_n = '0;
            mem_idx_n   = '0;
            buf_clr     = 1'b1;
         end
      end else if (mode_btn) begin
         case (state)
            ST_OFF: state_n = ST_SW;
            ST_SW:  state_n = ST_TMR;
            ST_TMR: begin
               if (lap_count == '0) begin
                  state_n = ST_OFF;
               end else begin
                  state_n   = ST_RECALL;
                  mem_idx_n = '0;
               end
            end
            ST_RECALL: state_n = ST_OFF;
            default:   state_n = state;
         endcase
      end else if (lap_btn) begin
         if (state == ST_SW && !buf_full) begin
            buf_wr      = 1'b1;
            lap_count_n = lap_count + CW'(1);
         end
      end else if (recall_btn) begin
         if (state == ST_RECALL) begin
            mem_idx_n = idx_last ? '0 : mem_idx + IW'(1);
         end
      end
   end

   // Control registers: mode, the mode to return to after an alarm, the
   // alarm hold counter, the lap fill level and the displayed lap index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_OFF;
         saved     <= ST_OFF;
         alarm_cnt <= '0;
         lap_count <= '0;
         mem_idx   <= '0;
      end else begin
         state     <= state_n;
         saved     <= saved_n;
         alarm_cnt <= alarm_cnt_n;
         lap_count <= lap_count_n;
         mem_idx   <= mem_idx_n;
      end
   end

   // Lap storage. New laps always land at the current fill level, so the
   // oldest lap sits at entry 0. Clearing zeroes every entry so a cleared
   // buffer shows 0 on mem rather than stale lap times.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst || buf_clr) begin
            lap_buf[i] <= '0;
         end else if (buf_wr && (lap_count == CW'(i))) begin
            lap_buf[i] <= stopwatch;
         end
      end
   end

   // Output decode straight from the state register. The alarm view shows
   // the timer (code 2) with the alarm flag raised; mem is a plain read of
   // the registered buffer at the registered index.
   always_comb begin
      output_select = 2'd0;
      case (state)
         ST_OFF:    output_select = 2'd0;
         ST_SW:     output_select = 2'd1;
         ST_TMR:    output_select = 2'd2;
         ST_RECALL: output_select = 2'd3;
         ST_ALARM:  output_select = 2'd2;
         default:   output_select = 2'd0;
      endcase
      alarm = (state == ST_ALARM);
      mem   = lap_buf[mem_idx];
   end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_mode_ctrl
//
// Self-checking bench for display_mode_ctrl with a short alarm hold time.
// Every stimulus cycle advances a behavioural model of the display (current
// view, a list of stored laps, an alarm countdown) and queues the outputs it
// predicts; an independent monitor pops one prediction per clock and compares
// it with the design. Directed scenarios add fixed-value spot checks.
// ---------------------------------------------------------------------------
module tb_display_mode_ctrl;

   localparam int W         = 12;
   localparam int DEPTH     = 4;
   localparam int ALARM_CYC = 8;

   logic                         clk;
   logic                         rst;
   logic                         mode_btn;
   logic                         lap_btn;
   logic                         recall_btn;
   logic                         clear_btn;
   logic                         timer_done;
   logic [W-1:0]                 stopwatch;
   logic [1:0]                   output_select;
   logic [W-1:0]                 mem;
   logic [$clog2(DEPTH)-1:0]     mem_idx;
   logic [$clog2(DEPTH+1)-1:0]   lap_count;
   logic                         alarm;

   typedef struct {
      int osel;
      int mem;
      int idx;
      int cnt;
      int alm;
   } exp_t;

   exp_t sb_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;

   int   m_view;
   bit   m_in_alarm;
   int   m_left;
   int   m_laps[$];
   int   m_idx;

   display_mode_ctrl #(
      .W         (W),
      .DEPTH     (DEPTH),
      .ALARM_CYC (ALARM_CYC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mode_btn      (mode_btn),
      .lap_btn       (lap_btn),
      .recall_btn    (recall_btn),
      .clear_btn     (clear_btn),
      .timer_done    (timer_done),
      .stopwatch     (stopwatch),
      .output_select (output_select),
      .mem           (mem),
      .mem_idx       (mem_idx),
      .lap_count     (lap_count),
      .alarm         (alarm)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck run still ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d", n_compared);
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model. The view is an integer 0..3 that stays frozen while an
   // alarm is pending; the alarm is a countdown of remaining visible cycles;
   // laps are a list in arrival order.
   function automatic void model_step(input bit r, input bit md, input bit lp,
                                      input bit rc, input bit cl, input bit td,
                                      input int sw);
      if (r) begin
         m_view     = 0;
         m_in_alarm = 1'b0;
         m_left     = 0;
         m_laps.delete();
         m_idx      = 0;
      end else if (td) begin
         m_in_alarm = 1'b1;
         m_left     = ALARM_CYC;
      end else if (m_in_alarm) begin
         if (md || lp || rc || cl) begin
            m_in_alarm = 1'b0;
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_in_alarm = 1'b0;
         end
      end else if (cl) begin
         if (m_view == 3) begin
            m_laps.delete();
            m_idx  = 0;
            m_view = 0;
         end
      end else if (md) begin
         if (m_view == 0)      m_view = 1;
         else if (m_view == 1) m_view = 2;
         else if (m_view == 2) begin
            if (m_laps.size() == 0) m_view = 0;
            else begin
               m_view = 3;
               m_idx  = 0;
            end
         end else m_view = 0;
      end else if (lp) begin
         if (m_view == 1 && m_laps.size() < DEPTH) m_laps.push_back(sw);
      end else if (rc) begin
         if (m_view == 3 && m_laps.size() > 0) m_idx = (m_idx + 1) % m_laps.size();
      end
   endfunction

   function automatic exp_t model_outputs();
      exp_t e;
      e.osel = m_in_alarm ? 2 : m_view;
      e.mem  = (m_idx < m_laps.size()) ? m_laps[m_idx] : 0;
      e.idx  = m_idx;
      e.cnt  = m_laps.size();
      e.alm  = m_in_alarm ? 1 : 0;
      return e;
   endfunction

   // One comparison: count it, report it if it differs.
   task automatic checkOutput(input string name, input int actual, input int expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model and
   // queue its prediction, then return just after the capturing rising edge.
   task automatic applyStimulus(input bit r, input bit md, input bit lp,
                                input bit rc, input bit cl, input bit td,
                                input int sw);
      @(negedge clk);
      rst        = r;
      mode_btn   = md;
      lap_btn    = lp;
      recall_btn = rc;
      clear_btn  = cl;
      timer_done = td;
      stopwatch  = W'(sw);
      model_step(r, md, lp, rc, cl, td, sw);
      sb_q.push_back(model_outputs());
      @(posedge clk);
      #2;
   endtask

   // Raise timer_done, then idle for a bounded window while counting the
   // cycles in which alarm is visible. With extend set, a second timer_done
   // is issued during the fifth visible alarm cycle.
   task automatic alarmWindow(input bit extend, output int highs);
      highs = 0;
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      if (alarm) highs++;
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(0, 0, 0, 0, 0, extend && (k == 5), 0);
         if (alarm) highs++;
      end
   endtask

   // Monitor: one prediction per clock once stimulus has begun.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("sb_output_select", int'(output_select), e.osel);
            checkOutput("sb_mem",           int'(mem),           e.mem);
            checkOutput("sb_mem_idx",       int'(mem_idx),       e.idx);
            checkOutput("sb_lap_count",     int'(lap_count),     e.cnt);
            checkOutput("sb_alarm",         int'(alarm),         e.alm);
         end
      end
   end

   // Directed scenarios followed by a randomized run.
   initial begin
      int highs;
      bit r, md, lp, rc, cl, td;

      rst        = 1'b1;
      mode_btn   = 1'b0;
      lap_btn    = 1'b0;
      recall_btn = 1'b0;
      clear_btn  = 1'b0;
      timer_done = 1'b0;
      stopwatch  = '0;
      model_step(1, 0, 0, 0, 0, 0, 0);

      $display("[TB] reset");
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("rst_output_select", int'(output_select), 0);
      checkOutput("rst_lap_count",     int'(lap_count),     0);
      checkOutput("rst_mem",           int'(mem),           0);
      checkOutput("rst_alarm",         int'(alarm),         0);

      $display("[TB] two laps and recall wrap");
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("sw_output_select", int'(output_select), 1);
      applyStimulus(0, 0, 1, 0, 0, 0, 65);
      applyStimulus(0, 0, 1, 0, 0, 0, 130);
      checkOutput("two_laps_count", int'(lap_count), 2);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("recall_output_select", int'(output_select), 3);
      checkOutput("recall_first_mem",     int'(mem),           65);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("recall_second_mem", int'(mem), 130);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("recall_wrap_mem", int'(mem), 65);

      $display("[TB] alarm from recall");
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("recall_idx_one", int'(mem_idx), 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("alarm_output_select", int'(output_select), 2);
      checkOutput("alarm_flag",          int'(alarm),         1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("ack_output_select", int'(output_select), 3);
      checkOutput("ack_mem_idx",       int'(mem_idx),       1);
      checkOutput("ack_alarm",         int'(alarm),         0);

      $display("[TB] timer_done beats clear");
      applyStimulus(0, 0, 0, 0, 1, 1, 0);
      checkOutput("td_clear_alarm",     int'(alarm),     1);
      checkOutput("td_clear_lap_count", int'(lap_count), 2);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("clear_output_select", int'(output_select), 0);
      checkOutput("clear_lap_count",     int'(lap_count),     0);
      checkOutput("clear_mem",           int'(mem),           0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("tmr_output_select", int'(output_select), 2);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("tmr_skip_recall", int'(output_select), 0);

      $display("[TB] lap buffer full");
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      for (int v = 1; v <= 5; v++) applyStimulus(0, 0, 1, 0, 0, 0, v);
      checkOutput("full_lap_count", int'(lap_count), DEPTH);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("clear_in_sw_select", int'(output_select), 1);
      checkOutput("clear_in_sw_count",  int'(lap_count),     DEPTH);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("full_first_mem", int'(mem), 1);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("full_last_mem", int'(mem), 4);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("full_wrap_mem", int'(mem), 1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);

      $display("[TB] alarm hold time");
      alarmWindow(1'b0, highs);
      checkOutput("alarm_hold_cycles", highs, ALARM_CYC);
      checkOutput("alarm_return_select", int'(output_select), 1);
      alarmWindow(1'b1, highs);
      checkOutput("alarm_extended_cycles", highs, ALARM_CYC + 5);
      checkOutput("alarm_ext_return_select", int'(output_select), 1);

      $display("[TB] reset during alarm");
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("pre_rst_alarm", int'(alarm), 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("alarm_rst_select",    int'(output_select), 0);
      checkOutput("alarm_rst_lap_count", int'(lap_count),     0);
      checkOutput("alarm_rst_mem",       int'(mem),           0);
      checkOutput("alarm_rst_alarm",     int'(alarm),         0);
      checkOutput("alarm_rst_mem_idx",   int'(mem_idx),       0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("post_rst_tmr_to_off", int'(output_select), 0);

      $display("[TB] randomized run");
      for (int n = 0; n < 2000; n++) begin
         r  = ($urandom_range(0, 299) == 0);
         md = ($urandom_range(0, 5) == 0);
         lp = ($urandom_range(0, 3) == 0);
         rc = ($urandom_range(0, 4) == 0);
         cl = ($urandom_range(0, 11) == 0);
         td = ($urandom_range(0, 39) == 0);
         applyStimulus(r, md, lp, rc, cl, td, int'($urandom_range(0, 4095)));
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      #5;
      checkOutput("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
